// File: rtl/ap_perf_mon_pkg.sv
// Shared types, register map and saturating arithmetic for ap_ctrl_perf_monitor.
package ap_perf_mon_pkg;

  // Per-channel ap_ctrl tracking state
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } ch_state_e;

  localparam int unsigned RD_REG_W  = 3;
  localparam int unsigned MAX_CNT_W = 64;

  // Read-port register map
  localparam logic [RD_REG_W-1:0] REG_INV    = 3'd0;
  localparam logic [RD_REG_W-1:0] REG_LAST   = 3'd1;
  localparam logic [RD_REG_W-1:0] REG_STALL  = 3'd2;
  localparam logic [RD_REG_W-1:0] REG_ITER   = 3'd3;
  localparam logic [RD_REG_W-1:0] REG_READY  = 3'd4;
  localparam logic [RD_REG_W-1:0] REG_STATUS = 3'd5;
  localparam logic [RD_REG_W-1:0] REG_MIN    = 3'd6;
  localparam logic [RD_REG_W-1:0] REG_MAX    = 3'd7;

  // Increment that sticks at the all-ones value of a width-bit counter
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                   input int unsigned width);
    logic [MAX_CNT_W-1:0] max_val;
    max_val = (width >= MAX_CNT_W) ? {MAX_CNT_W{1'b1}}
                                   : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
    return (val >= max_val) ? max_val : val + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ap_ctrl_ch_tracker.sv
// One monitored ap_ctrl channel: handshake FSM plus saturating counters.
// Min/max latency storage exists only when AP_PERF_MON_MINMAX_EN is defined.
module ap_ctrl_ch_tracker
  import ap_perf_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             ready_i,
  input  logic             done_i,
  input  logic             continue_i,
  input  logic             iter_i,
  input  logic             clear_i,
  input  logic             freeze_i,
  output ch_state_e        state_o,
  output logic             busy_o,
  output logic             sat_o,
  output logic             sat_nxt_c,
  output logic [CNT_W-1:0] inv_cnt_o,
  output logic [CNT_W-1:0] last_lat_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] iter_cnt_o,
  output logic [CNT_W-1:0] ready_cnt_o,
  output logic [CNT_W-1:0] min_lat_o,
  output logic [CNT_W-1:0] max_lat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(MAX_CNT_W'(v), CNT_W));
  endfunction

  ch_state_e        state_q, state_d;
  logic             busy_q;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] inv_q, inv_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] ready_q, ready_d;
  logic             sat_q, sat_d;

  logic             fin_ev;
  logic             fin_sat;
  logic [CNT_W-1:0] fin_lat;
  logic             stall_ev;

  // Handshake FSM and running latency; flags invocation end and stall cycles
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    fin_ev   = 1'b0;
    fin_sat  = 1'b0;
    fin_lat  = '0;
    stall_ev = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          lat_d = CNT_W'(1);
          if (done_i) begin
            fin_ev  = 1'b1;
            fin_lat = CNT_W'(1);
            state_d = continue_i ? IDLE : DONE_WAIT;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        lat_d = inc(lat_q);
        if (done_i) begin
          fin_ev  = 1'b1;
          fin_lat = inc(lat_q);
          fin_sat = (lat_q == CNT_MAX);
          state_d = continue_i ? IDLE : DONE_WAIT;
        end
      end
      DONE_WAIT: begin
        if (continue_i) begin
          state_d = IDLE;
        end else begin
          stall_ev = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter updates: clear wins, freeze holds, otherwise saturating increments
  always_comb begin
    inv_d   = inv_q;
    last_d  = last_q;
    stall_d = stall_q;
    iter_d  = iter_q;
    ready_d = ready_q;
    sat_d   = sat_q;
    if (clear_i) begin
      inv_d   = '0;
      last_d  = '0;
      stall_d = '0;
      iter_d  = '0;
      ready_d = '0;
      sat_d   = 1'b0;
    end else if (!freeze_i) begin
      if (fin_ev) begin
        inv_d  = inc(inv_q);
        last_d = fin_lat;
        sat_d  = sat_d | (inv_q == CNT_MAX) | fin_sat;
      end
      if (stall_ev) begin
        stall_d = inc(stall_q);
        sat_d   = sat_d | (stall_q == CNT_MAX);
      end
      if (ready_i) begin
        ready_d = inc(ready_q);
        sat_d   = sat_d | (ready_q == CNT_MAX);
      end
      if (iter_i && (state_q != IDLE)) begin
        iter_d = inc(iter_q);
        sat_d  = sat_d | (iter_q == CNT_MAX);
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      lat_q   <= '0;
      inv_q   <= '0;
      last_q  <= '0;
      stall_q <= '0;
      iter_q  <= '0;
      ready_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      lat_q   <= lat_d;
      inv_q   <= inv_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      iter_q  <= iter_d;
      ready_q <= ready_d;
      sat_q   <= sat_d;
    end
  end

`ifdef AP_PERF_MON_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  // Track extreme latencies alongside LAST_LAT
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear_i) begin
      min_d = CNT_MAX;
      max_d = '0;
    end else if (!freeze_i && fin_ev) begin
      if (fin_lat < min_q) min_d = fin_lat;
      if (fin_lat > max_q) max_d = fin_lat;
    end
  end

  // Min/max registers; min starts at all-ones so the first latency always lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= CNT_MAX;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_lat_o = min_q;
  assign max_lat_o = max_q;
`else
  assign min_lat_o = '0;
  assign max_lat_o = '0;
`endif

  assign state_o     = state_q;
  assign busy_o      = busy_q;
  assign sat_o       = sat_q;
  assign sat_nxt_c   = sat_d;
  assign inv_cnt_o   = inv_q;
  assign last_lat_o  = last_q;
  assign stall_cnt_o = stall_q;
  assign iter_cnt_o  = iter_q;
  assign ready_cnt_o = ready_q;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Performance monitor for NUM_CH HLS ap_ctrl handshakes with a registered read port.
// Optional min/max latency tracking: define AP_PERF_MON_MINMAX_EN.
module ap_ctrl_perf_monitor
  import ap_perf_mon_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                                       ap_clk,
  input  logic                                       ap_rst_n,
  input  logic [NUM_CH-1:0]                          mon_ap_start,
  input  logic [NUM_CH-1:0]                          mon_ap_ready,
  input  logic [NUM_CH-1:0]                          mon_ap_done,
  input  logic [NUM_CH-1:0]                          mon_ap_continue,
  input  logic [NUM_CH-1:0]                          mon_iter_strobe,
  input  logic                                       clear,
  input  logic                                       freeze,
  input  logic                                       rd_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  input  logic [RD_REG_W-1:0]                        rd_reg,
  output logic                                       rd_valid,
  output logic [CNT_W-1:0]                           rd_data,
  output logic [NUM_CH-1:0]                          busy_vec,
  output logic                                       any_sat
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  ch_state_e        ch_state  [NUM_CH];
  logic [CNT_W-1:0] inv_cnt   [NUM_CH];
  logic [CNT_W-1:0] last_lat  [NUM_CH];
  logic [CNT_W-1:0] stall_cnt [NUM_CH];
  logic [CNT_W-1:0] iter_cnt  [NUM_CH];
  logic [CNT_W-1:0] ready_cnt [NUM_CH];
  logic [CNT_W-1:0] min_lat   [NUM_CH];
  logic [CNT_W-1:0] max_lat   [NUM_CH];
  logic [NUM_CH-1:0] sat_vec;
  logic [NUM_CH-1:0] sat_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_ctrl_ch_tracker #(
      .CNT_W(CNT_W)
    ) u_trk (
      .clk        (ap_clk),
      .rst_n      (ap_rst_n),
      .start_i    (mon_ap_start[g]),
      .ready_i    (mon_ap_ready[g]),
      .done_i     (mon_ap_done[g]),
      .continue_i (mon_ap_continue[g]),
      .iter_i     (mon_iter_strobe[g]),
      .clear_i    (clear),
      .freeze_i   (freeze),
      .state_o    (ch_state[g]),
      .busy_o     (busy_vec[g]),
      .sat_o      (sat_vec[g]),
      .sat_nxt_c  (sat_nxt[g]),
      .inv_cnt_o  (inv_cnt[g]),
      .last_lat_o (last_lat[g]),
      .stall_cnt_o(stall_cnt[g]),
      .iter_cnt_o (iter_cnt[g]),
      .ready_cnt_o(ready_cnt[g]),
      .min_lat_o  (min_lat[g]),
      .max_lat_o  (max_lat[g])
    );
  end

  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             any_sat_q;

  // Read mux over current (pre-update) register values; out-of-range reads give 0
  always_comb begin
    rd_data_d = '0;
    if (32'(rd_ch) < NUM_CH) begin
      case (rd_reg)
        REG_INV:    rd_data_d = inv_cnt[rd_ch];
        REG_LAST:   rd_data_d = last_lat[rd_ch];
        REG_STALL:  rd_data_d = stall_cnt[rd_ch];
        REG_ITER:   rd_data_d = iter_cnt[rd_ch];
        REG_READY:  rd_data_d = ready_cnt[rd_ch];
        REG_STATUS: rd_data_d = CNT_W'({sat_vec[rd_ch], 2'(ch_state[rd_ch])});
        REG_MIN:    rd_data_d = min_lat[rd_ch];
        REG_MAX:    rd_data_d = max_lat[rd_ch];
        default:    rd_data_d = '0;
      endcase
    end
  end

  // Read-port and saturation-summary registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      any_sat_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_data_d;
      any_sat_q  <= |sat_nxt;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign any_sat  = any_sat_q;

  logic unused_ok;
  assign unused_ok = ^CH_W;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed self-checking bench for ap_ctrl_perf_monitor (NUM_CH=3, CNT_W=8).
module tb_ap_ctrl_perf_monitor;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 8;

  logic              ap_clk;
  logic              ap_rst_n;
  logic [NUM_CH-1:0] mon_ap_start;
  logic [NUM_CH-1:0] mon_ap_ready;
  logic [NUM_CH-1:0] mon_ap_done;
  logic [NUM_CH-1:0] mon_ap_continue;
  logic [NUM_CH-1:0] mon_iter_strobe;
  logic              clear;
  logic              freeze;
  logic              rd_en;
  logic [1:0]        rd_ch;
  logic [2:0]        rd_reg;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] busy_vec;
  logic              any_sat;

  int total = 0;
  int bad   = 0;

  ap_ctrl_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .mon_ap_start   (mon_ap_start),
    .mon_ap_ready   (mon_ap_ready),
    .mon_ap_done    (mon_ap_done),
    .mon_ap_continue(mon_ap_continue),
    .mon_iter_strobe(mon_iter_strobe),
    .clear          (clear),
    .freeze         (freeze),
    .rd_en          (rd_en),
    .rd_ch          (rd_ch),
    .rd_reg         (rd_reg),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .busy_vec       (busy_vec),
    .any_sat        (any_sat)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic rd(input int ch, input int r, output logic [CNT_W-1:0] d, output logic v);
    rd_ch  = 2'(ch);
    rd_reg = 3'(r);
    rd_en  = 1'b1;
    tick();
    d     = rd_data;
    v     = rd_valid;
    rd_en = 1'b0;
  endtask

  // One invocation of latency lat (>= 2) on channel ch, continue high
  task automatic do_inv(input int ch, input int lat);
    mon_ap_start[ch] = 1'b1;
    tick();
    mon_ap_start[ch] = 1'b0;
    repeat (lat - 2) tick();
    mon_ap_done[ch] = 1'b1;
    tick();
    mon_ap_done[ch] = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n        = 1'b0;
    mon_ap_start    = '0;
    mon_ap_ready    = '0;
    mon_ap_done     = '0;
    mon_ap_continue = '1;
    mon_iter_strobe = '0;
    clear  = 1'b0;
    freeze = 1'b0;
    rd_en  = 1'b0;
    rd_ch  = '0;
    rd_reg = '0;
    repeat (3) tick();
    total++;
    if ({rd_valid, rd_data, busy_vec, any_sat} !== '0) begin
      $display("FAIL reset_outputs got=%0h exp=0", {rd_valid, rd_data, busy_vec, any_sat});
      bad++;
    end
    ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_latency();
    logic [CNT_W-1:0] d;
    logic v;
    mon_ap_start[0] = 1'b1;
    tick();
    mon_ap_start[0] = 1'b0;
    total++;
    if (busy_vec[0] !== 1'b1) begin
      $display("FAIL basic_busy_hi got=%0b exp=1", busy_vec[0]); bad++;
    end
    repeat (4) tick();
    mon_ap_done[0]  = 1'b1;
    mon_ap_ready[0] = 1'b1;
    tick();
    mon_ap_done[0]  = 1'b0;
    mon_ap_ready[0] = 1'b0;
    total++;
    if (busy_vec[0] !== 1'b0) begin
      $display("FAIL basic_busy_lo got=%0b exp=0", busy_vec[0]); bad++;
    end
    rd(0, 0, d, v);
    total++;
    if ({v, d} !== {1'b1, 8'd1}) begin
      $display("FAIL basic_inv got=%0b/%0d exp=1/1", v, d); bad++;
    end
    rd(0, 1, d, v);
    total++;
    if (d !== 8'd6) begin $display("FAIL basic_last_lat got=%0d exp=6", d); bad++; end
    rd(0, 2, d, v);
    total++;
    if (d !== 8'd0) begin $display("FAIL basic_stall got=%0d exp=0", d); bad++; end
    rd(0, 4, d, v);
    total++;
    if (d !== 8'd1) begin $display("FAIL basic_ready got=%0d exp=1", d); bad++; end
  endtask

  task automatic test_stall();
    logic [CNT_W-1:0] d;
    logic v;
    mon_ap_start[1]    = 1'b1;
    mon_ap_done[1]     = 1'b1;
    mon_ap_continue[1] = 1'b0;
    tick();
    mon_ap_start[1] = 1'b0;
    mon_ap_done[1]  = 1'b0;
    rd(1, 5, d, v);
    total++;
    if (d !== 8'd2) begin $display("FAIL stall_status got=%0d exp=2", d); bad++; end
    total++;
    if (busy_vec[1] !== 1'b1) begin
      $display("FAIL stall_busy got=%0b exp=1", busy_vec[1]); bad++;
    end
    repeat (2) tick();
    mon_ap_continue[1] = 1'b1;
    tick();
    rd(1, 2, d, v);
    total++;
    if (d !== 8'd3) begin $display("FAIL stall_cnt got=%0d exp=3", d); bad++; end
    rd(1, 1, d, v);
    total++;
    if (d !== 8'd1) begin $display("FAIL stall_last_lat got=%0d exp=1", d); bad++; end
    rd(1, 0, d, v);
    total++;
    if (d !== 8'd1) begin $display("FAIL stall_inv got=%0d exp=1", d); bad++; end
  endtask

  task automatic test_iter_saturation();
    logic [CNT_W-1:0] d;
    logic v;
    mon_iter_strobe[2] = 1'b1;
    repeat (5) tick();
    mon_iter_strobe[2] = 1'b0;
    rd(2, 3, d, v);
    total++;
    if (d !== 8'd0) begin $display("FAIL iter_idle_ignored got=%0d exp=0", d); bad++; end
    mon_ap_start[2] = 1'b1;
    tick();
    mon_ap_start[2]    = 1'b0;
    mon_iter_strobe[2] = 1'b1;
    repeat (300) tick();
    mon_iter_strobe[2] = 1'b0;
    rd(2, 3, d, v);
    total++;
    if (d !== 8'd255) begin $display("FAIL iter_sat_value got=%0d exp=255", d); bad++; end
    rd(2, 5, d, v);
    total++;
    if (d !== 8'd5) begin $display("FAIL iter_sat_status got=%0d exp=5", d); bad++; end
    total++;
    if (any_sat !== 1'b1) begin $display("FAIL iter_any_sat got=%0b exp=1", any_sat); bad++; end
    pulse_clear();
    total++;
    if (any_sat !== 1'b0) begin $display("FAIL clear_any_sat got=%0b exp=0", any_sat); bad++; end
    rd(2, 3, d, v);
    total++;
    if (d !== 8'd0) begin $display("FAIL clear_iter got=%0d exp=0", d); bad++; end
    rd(2, 5, d, v);
    total++;
    if (d !== 8'd1) begin $display("FAIL clear_status got=%0d exp=1", d); bad++; end
    mon_ap_done[2] = 1'b1;
    tick();
    mon_ap_done[2] = 1'b0;
    rd(2, 1, d, v);
    total++;
    if (d !== 8'd255) begin $display("FAIL lat_sat_value got=%0d exp=255", d); bad++; end
    total++;
    if (any_sat !== 1'b1) begin $display("FAIL lat_sat_any got=%0b exp=1", any_sat); bad++; end
  endtask

  task automatic test_clear_freeze();
    logic [CNT_W-1:0] d;
    logic v;
    pulse_clear();
    mon_ap_start[0] = 1'b1;
    tick();
    mon_ap_start[0] = 1'b0;
    tick();
    mon_ap_done[0] = 1'b1;
    clear          = 1'b1;
    tick();
    mon_ap_done[0] = 1'b0;
    clear          = 1'b0;
    rd(0, 0, d, v);
    total++;
    if (d !== 8'd0) begin $display("FAIL clear_vs_done_inv got=%0d exp=0", d); bad++; end
    freeze = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mon_ap_start[0] = 1'b1;
      mon_ap_ready[0] = 1'b1;
      tick();
      mon_ap_start[0] = 1'b0;
      mon_ap_ready[0] = 1'b0;
      total++;
      if (busy_vec[0] !== 1'b1) begin
        $display("FAIL freeze_busy_hi got=%0b exp=1", busy_vec[0]); bad++;
      end
      mon_ap_done[0] = 1'b1;
      tick();
      mon_ap_done[0] = 1'b0;
      total++;
      if (busy_vec[0] !== 1'b0) begin
        $display("FAIL freeze_busy_lo got=%0b exp=0", busy_vec[0]); bad++;
      end
    end
    freeze = 1'b0;
    rd(0, 0, d, v);
    total++;
    if (d !== 8'd0) begin $display("FAIL freeze_inv got=%0d exp=0", d); bad++; end
    rd(0, 4, d, v);
    total++;
    if (d !== 8'd0) begin $display("FAIL freeze_ready got=%0d exp=0", d); bad++; end
    do_inv(0, 2);
    rd(0, 0, d, v);
    total++;
    if (d !== 8'd1) begin $display("FAIL unfreeze_inv got=%0d exp=1", d); bad++; end
    rd(0, 1, d, v);
    total++;
    if (d !== 8'd2) begin $display("FAIL unfreeze_last got=%0d exp=2", d); bad++; end
  endtask

  task automatic test_oob_minmax();
    logic [CNT_W-1:0] d;
    logic v;
    logic [CNT_W-1:0] exp_min;
    logic [CNT_W-1:0] exp_max;
    rd(3, 0, d, v);
    total++;
    if ({v, d} !== {1'b1, 8'd0}) begin
      $display("FAIL oob_read got=%0b/%0d exp=1/0", v, d); bad++;
    end
    pulse_clear();
    do_inv(0, 4);
    do_inv(0, 9);
    do_inv(0, 2);
`ifdef AP_PERF_MON_MINMAX_EN
    exp_min = 8'd2;
    exp_max = 8'd9;
`else
    exp_min = 8'd0;
    exp_max = 8'd0;
`endif
    rd(0, 1, d, v);
    total++;
    if (d !== 8'd2) begin $display("FAIL mm_last got=%0d exp=2", d); bad++; end
    rd(0, 0, d, v);
    total++;
    if (d !== 8'd3) begin $display("FAIL mm_inv got=%0d exp=3", d); bad++; end
    rd(0, 6, d, v);
    total++;
    if (d !== exp_min) begin $display("FAIL mm_min got=%0d exp=%0d", d, exp_min); bad++; end
    rd(0, 7, d, v);
    total++;
    if (d !== exp_max) begin $display("FAIL mm_max got=%0d exp=%0d", d, exp_max); bad++; end
  endtask

  task automatic test_reset_mid();
    logic [CNT_W-1:0] d;
    logic v;
    mon_ap_start = '1;
    tick();
    mon_ap_start = '0;
    tick();
    total++;
    if (busy_vec !== 3'b111) begin $display("FAIL mid_busy got=%0b exp=111", busy_vec); bad++; end
    rd_ch  = 2'd0;
    rd_reg = 3'd1;
    rd_en  = 1'b1;
    tick();
    rd_en    = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    total++;
    if ({rd_valid, rd_data, busy_vec, any_sat} !== '0) begin
      $display("FAIL mid_reset_outputs got=%0h exp=0", {rd_valid, rd_data, busy_vec, any_sat});
      bad++;
    end
    #2;
    ap_rst_n = 1'b1;
    tick();
    do_inv(0, 3);
    rd(0, 0, d, v);
    total++;
    if (d !== 8'd1) begin $display("FAIL post_reset_inv got=%0d exp=1", d); bad++; end
    rd(0, 1, d, v);
    total++;
    if (d !== 8'd3) begin $display("FAIL post_reset_last got=%0d exp=3", d); bad++; end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_stall();
    test_iter_saturation();
    test_clear_freeze();
    test_oob_minmax();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
